cam_stream_gen: RTL and testbench

//  OV7670-style parallel video source emulator: drives pclk/vsync/href/data[7:0] as the

---
 rtl/cam_stream_gen.sv | 190 +++++++++++++++++++
 tb/tb_cam_stream_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cam_stream_gen.sv
// OV7670-style parallel video source: replays a frame buffer as pclk/vsync/href/data
// (RGB555, two bytes per pixel), fetching each pixel one byte period ahead of use.
module cam_stream_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int PCLK_DIV    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        pix_rd,
  output logic [8:0]  pix_row,
  output logic [9:0]  pix_col,
  input  logic [14:0] pix_data,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic        busy
);

  localparam int L    = 2*H_ACTIVE + H_BLANK;
  localparam int HALF = PCLK_DIV/2;
  localparam int PW   = $clog2(PCLK_DIV);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  // Successor of a state, skipping zero-length states; S_IDLE means "frame over".
  // Called with S_IDLE it returns the first state of a frame.
  function automatic state_t after(input state_t s);
    state_t r;
    r = S_IDLE;
    case (s)
      S_IDLE:   r = (VSYNC_LINES > 0) ? S_VSYNC : (V_BACK > 0) ? S_VBACK :
                    (V_ACTIVE > 0) ? S_ACTIVE : S_VFRONT;
      S_VSYNC:  r = (V_BACK > 0) ? S_VBACK : (V_ACTIVE > 0) ? S_ACTIVE :
                    (V_FRONT > 0) ? S_VFRONT : S_IDLE;
      S_VBACK:  r = (V_ACTIVE > 0) ? S_ACTIVE : (V_FRONT > 0) ? S_VFRONT : S_IDLE;
      S_ACTIVE: r = (V_FRONT > 0) ? S_VFRONT : S_IDLE;
      default:  r = S_IDLE;
    endcase
    return r;
  endfunction

  function automatic logic [9:0] last_line(input state_t s);
    logic [9:0] r;
    r = '0;
    case (s)
      S_VSYNC:  r = 10'(VSYNC_LINES - 1);
      S_VBACK:  r = 10'(V_BACK - 1);
      S_ACTIVE: r = 10'(V_ACTIVE - 1);
      S_VFRONT: r = 10'(V_FRONT - 1);
      default:  r = '0;
    endcase
    return r;
  endfunction

  state_t        state, state_nx;
  logic [PW-1:0] ph, ph_nx;
  logic [10:0]   byte_cnt, byte_nx;
  logic [9:0]    line_cnt, line_nx;
  logic [14:0]   pix_hold, cur_pix;
  logic          rd_d1;
  logic          tick, upd, frame_end, fetch, last_ln;
  logic [8:0]    f_row;
  logic [9:0]    f_col;
  logic          vsync_nx, href_nx, pclk_nx;
  logic [7:0]    data_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ph_nx     = ph;
    byte_nx   = byte_cnt;
    line_nx   = line_cnt;
    frame_end = 1'b0;
    fetch     = 1'b0;
    f_row     = pix_row;
    f_col     = pix_col;
    upd       = 1'b0;
    tick      = (ph == PW'(PCLK_DIV - 1));
    last_ln   = (line_cnt == last_line(state));

    if (state == S_IDLE) begin
      ph_nx = '0;
      upd   = 1'b1;
      if (en) begin
        state_nx = after(S_IDLE);
        byte_nx  = '0;
        line_nx  = '0;
      end
    end else begin
      ph_nx = tick ? '0 : ph + 1'b1;
      if (tick) begin
        upd = 1'b1;
        if (byte_cnt == 11'(L - 1)) begin
          byte_nx = '0;
          if (last_ln) begin
            line_nx  = '0;
            state_nx = after(state);
            if (state_nx == S_IDLE) begin
              frame_end = 1'b1;
              state_nx  = en ? after(S_IDLE) : S_IDLE;
            end
          end else begin
            line_nx = line_cnt + 10'd1;
          end
        end else begin
          byte_nx = byte_cnt + 11'd1;
        end
      end

      // Fetch is issued so that pix_rd lands on the pclk rising clk of the
      // period just before the pixel's first byte.
      if (ph == PW'(HALF - 1)) begin
        if (state == S_ACTIVE && byte_cnt[0] && byte_cnt < 11'(2*H_ACTIVE - 1)) begin
          fetch = 1'b1;
          f_row = line_cnt[8:0];
          f_col = 10'((byte_cnt + 11'd1) >> 1);
        end else if (byte_cnt == 11'(L - 1)) begin
          if (state == S_ACTIVE && !last_ln) begin
            fetch = 1'b1;
            f_row = 9'(line_cnt + 10'd1);
            f_col = '0;
          end else if (last_ln && state != S_ACTIVE && after(state) == S_ACTIVE) begin
            fetch = 1'b1;
            f_row = '0;
            f_col = '0;
          end
        end
      end
    end

    // Even bytes may need the pixel arriving this very clk; odd bytes use the held copy.
    cur_pix  = rd_d1 ? pix_data : pix_hold;
    vsync_nx = (state_nx == S_VSYNC);
    href_nx  = (state_nx == S_ACTIVE) && (byte_nx < 11'(2*H_ACTIVE));
    data_nx  = '0;
    if (href_nx) data_nx = byte_nx[0] ? pix_hold[7:0] : {1'b0, cur_pix[14:8]};
    pclk_nx  = (state_nx != S_IDLE) && (ph_nx >= PW'(HALF));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph         <= '0;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      pclk       <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= '0;
      pix_rd     <= 1'b0;
      pix_row    <= '0;
      pix_col    <= '0;
      rd_d1      <= 1'b0;
      pix_hold   <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ph         <= ph_nx;
      byte_cnt   <= byte_nx;
      line_cnt   <= line_nx;
      pclk       <= pclk_nx;
      frame_done <= frame_end;
      busy       <= (state_nx != S_IDLE);
      pix_rd     <= fetch;
      rd_d1      <= pix_rd;
      if (fetch) begin
        pix_row <= f_row;
        pix_col <= f_col;
      end
      if (rd_d1) pix_hold <= pix_data;
      if (upd) begin
        vsync <= vsync_nx;
        href  <= href_nx;
        data  <= data_nx;
      end
    end
  end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen with a tiny frame (4x3 active, 10 pclk per line,
// 6 lines, 4 clk per pclk): 240 clk per frame, frame start = first clk with busy=1.
module tb_cam_stream_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        pix_rd;
  logic [8:0]  pix_row;
  logic [9:0]  pix_col;
  logic [14:0] pix_data = '0;
  logic        pclk, vsync, href, frame_done, busy;
  logic [7:0]  data;

  cam_stream_gen #(
    .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .VSYNC_LINES(1),
    .V_BACK(1), .V_FRONT(1), .PCLK_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .pix_rd(pix_rd), .pix_row(pix_row), .pix_col(pix_col), .pix_data(pix_data),
    .pclk(pclk), .vsync(vsync), .href(href), .data(data),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Frame buffer model: 1-clk read latency. Address mode gives even byte 0x10+row,
  // odd byte 0xC0+col.
  logic const_mode = 1'b0;
  always @(posedge clk)
    if (pix_rd)
      pix_data <= const_mode ? 15'h5A3C : {3'b001, pix_row[3:0], 2'b11, pix_col[5:0]};

  typedef struct {
    int         t;
    logic       pclk, vsync, href;
    logic [7:0] data;
    logic       rd;
    logic [8:0] row;
    logic [9:0] col;
    logic       busy, fd;
  } vec_t;

  vec_t vec[$];
  int n_cmp = 0, n_bad = 0;
  int t = 0;
  int rd_cnt, fd_cnt, pclk_hi, href_clks, pat_err, busy_hi;
  logic chk_pat = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic add(input int tt, input logic pc, vs, hr, input logic [7:0] d,
                     input logic rd, input logic [8:0] row, input logic [9:0] col,
                     input logic bz, fd);
    vec_t v;
    v.t = tt; v.pclk = pc; v.vsync = vs; v.href = hr; v.data = d;
    v.rd = rd; v.row = row; v.col = col; v.busy = bz; v.fd = fd;
    vec.push_back(v);
  endtask

  task automatic clr_counts();
    rd_cnt = 0; fd_cnt = 0; pclk_hi = 0; href_clks = 0; pat_err = 0; busy_hi = 0;
  endtask

  task automatic step();
    logic [7:0] exp_b;
    @(posedge clk); #1;
    t++;
    rd_cnt  += int'(pix_rd);
    fd_cnt  += int'(frame_done);
    pclk_hi += int'(pclk);
    busy_hi += int'(busy);
    if (href) href_clks++;
    if (chk_pat) begin
      exp_b = (((t / 4) % 10) % 2 == 0) ? 8'h5A : 8'h3C;
      if (href && data !== exp_b) pat_err++;
      if (!href && data !== 8'h00) pat_err++;
    end
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (n < 50) begin
      @(posedge clk); #1;
      if (busy) break;
      n++;
    end
    check("start_timeout", int'(busy), 1);
    t = 0;
  endtask

  initial begin
    // t, pclk, vsync, href, data, pix_rd, row, col, busy, frame_done
    add(  0, 0, 1, 0, 8'h00, 0, 0, 0, 1, 0);
    add(  2, 1, 1, 0, 8'h00, 0, 0, 0, 1, 0);
    add( 39, 1, 1, 0, 8'h00, 0, 0, 0, 1, 0);
    add( 40, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0);
    add( 78, 1, 0, 0, 8'h00, 1, 0, 0, 1, 0);
    add( 80, 0, 0, 1, 8'h10, 0, 0, 0, 1, 0);
    add( 84, 0, 0, 1, 8'hC0, 0, 0, 0, 1, 0);
    add( 86, 1, 0, 1, 8'hC0, 1, 0, 1, 1, 0);
    add( 88, 0, 0, 1, 8'h10, 0, 0, 0, 1, 0);
    add( 92, 0, 0, 1, 8'hC1, 0, 0, 0, 1, 0);
    add( 94, 1, 0, 1, 8'hC1, 1, 0, 2, 1, 0);
    add(108, 0, 0, 1, 8'hC3, 0, 0, 0, 1, 0);
    add(112, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0);
    add(118, 1, 0, 0, 8'h00, 1, 1, 0, 1, 0);
    add(120, 0, 0, 1, 8'h11, 0, 0, 0, 1, 0);
    add(168, 0, 0, 1, 8'h12, 0, 0, 0, 1, 0);
    add(198, 1, 0, 0, 8'h00, 0, 0, 0, 1, 0);
    add(200, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0);
    add(239, 1, 0, 0, 8'h00, 0, 0, 0, 1, 0);
    add(240, 0, 1, 0, 8'h00, 0, 0, 0, 1, 1);

    clr_counts();
    repeat (3) @(posedge clk);
    #1;
    check("rst_pclk", int'(pclk), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_vsync", int'(vsync), 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_pclk", int'(pclk), 0);

    // Frame 1 (address sweep) and back-to-back frame 2 with en dropped mid-ACTIVE
    en = 1'b1;
    wait_start();
    clr_counts();
    foreach (vec[i]) begin
      while (t < vec[i].t) step();
      check("v_pclk",  int'(pclk),       int'(vec[i].pclk));
      check("v_vsync", int'(vsync),      int'(vec[i].vsync));
      check("v_href",  int'(href),       int'(vec[i].href));
      check("v_data",  int'(data),       int'(vec[i].data));
      check("v_rd",    int'(pix_rd),     int'(vec[i].rd));
      check("v_busy",  int'(busy),       int'(vec[i].busy));
      check("v_fdone", int'(frame_done), int'(vec[i].fd));
      if (vec[i].rd) begin
        check("v_row", int'(pix_row), int'(vec[i].row));
        check("v_col", int'(pix_col), int'(vec[i].col));
      end
    end
    check("f1_rd_count", rd_cnt, 12);
    check("f1_href_clks", href_clks, 96);
    check("f1_fdone_count", fd_cnt, 1);

    clr_counts();
    while (t < 340) step();
    en = 1'b0;
    while (t < 480) step();
    check("f2_rd_count", rd_cnt, 12);
    check("f2_fdone_count", fd_cnt, 1);
    check("f2_fdone_at_end", int'(frame_done), 1);
    check("f2_busy_end", int'(busy), 0);
    check("f2_vsync_end", int'(vsync), 0);
    clr_counts();
    while (t < 500) step();
    check("idle_pclk_held", pclk_hi, 0);
    check("idle_busy", busy_hi, 0);
    check("idle_fdone", fd_cnt, 0);

    // Frame 3: constant pixel, single frame
    const_mode = 1'b1;
    en = 1'b1;
    wait_start();
    en = 1'b0;
    clr_counts();
    chk_pat = 1'b1;
    while (t < 240) step();
    chk_pat = 1'b0;
    check("f3_pattern_errs", pat_err, 0);
    check("f3_href_clks", href_clks, 96);
    check("f3_fdone_count", fd_cnt, 1);
    check("f3_busy_end", int'(busy), 0);

    // Frame 4: async reset mid-line while a fetch is in flight
    const_mode = 1'b0;
    en = 1'b1;
    wait_start();
    while (t < 94) step();
    check("pre_rst_rd", int'(pix_rd), 1);
    #1 rst = 1'b1;
    #1;
    check("arst_pclk",  int'(pclk),   0);
    check("arst_href",  int'(href),   0);
    check("arst_vsync", int'(vsync),  0);
    check("arst_data",  int'(data),   0);
    check("arst_rd",    int'(pix_rd), 0);
    check("arst_busy",  int'(busy),   0);
    en = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
